fmult_norm_round: RTL and testbench

Pipelined normalize-and-round back end for the single-precision floating-point multiplier. It takes the raw sign, exponent sum and 48-bit significand product from the multiplier array and returns a packed IEEE-754 binary32 result with status flags. Rounding is round-to-nearest-even; denormals are flushed to zero. The block uses a two-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_round_rne.sv | 25 ++
 rtl/fmult_norm_round.sv | 141 ++++++++++++++
 tb/tb_fmult_norm_round.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the floating-point back ends:
// class encodings, field widths, flag bit positions and the canonical NaN.
package fp_pkg;
    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_class_e;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Working exponent width: wide enough for sums below zero and past 255
    localparam int E_W = 11;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalized fraction with guard and
// sticky bits; a carry out of the fraction bumps the exponent.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0]     frac,
    input  logic                  g,
    input  logic                  s,
    input  logic signed [E_W-1:0] e,
    output logic [FRAC_W-1:0]     frac_rnd,
    output logic signed [E_W-1:0] e_adj,
    output logic                  carry,
    output logic                  inexact
);
    logic            round_up;
    logic [FRAC_W:0] sum;

    assign round_up = g & (s | frac[0]);
    assign sum      = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    assign carry    = sum[FRAC_W];
    // All-ones fraction rolled over: significand becomes 2.0, i.e. 1.0 x 2^(e+1)
    assign frac_rnd = carry ? '0 : sum[FRAC_W-1:0];
    assign e_adj    = e + $signed({{(E_W-1){1'b0}}, carry});
    assign inexact  = g | s;
endmodule

// File: rtl/fmult_norm_round.sv
// Two-stage normalize / round-and-pack back end of the binary32 multiplier,
// with a valid/ready handshake that sustains one result per cycle.
module fmult_norm_round #(
    parameter int          BIAS = fp_pkg::BIAS,
    parameter logic [31:0] QNAN = fp_pkg::QNAN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic [1:0]  in_class,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);
    import fp_pkg::*;

    localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);

    logic adv1, adv2;

    logic                  n;
    logic signed [E_W-1:0] e_n;
    logic [FRAC_W-1:0]     frac_n;
    logic                  g_n, s_n;

    logic                  s1_valid;
    logic                  s1_sign;
    logic signed [E_W-1:0] s1_e;
    logic [FRAC_W-1:0]     s1_frac;
    logic                  s1_g, s1_s;
    logic [1:0]            s1_class;

    logic [FRAC_W-1:0]     frac_rnd;
    logic signed [E_W-1:0] e_adj;
    logic                  carry, inexact;
    logic [31:0]           res_data;
    logic [2:0]            res_flags;

    logic s2_valid;

    assign adv2      = !s2_valid | out_ready;
    assign adv1      = !s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Stage 1: normalize the product so the leading one sits above frac
    assign n      = in_mant[47];
    assign e_n    = $signed({2'b00, in_exp}) - BIAS_E + $signed({{(E_W-1){1'b0}}, n});
    assign frac_n = n ? in_mant[46:24] : in_mant[45:23];
    assign g_n    = n ? in_mant[23]    : in_mant[22];
    assign s_n    = n ? |in_mant[22:0] : |in_mant[21:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_e     <= '0;
            s1_frac  <= '0;
            s1_g     <= 1'b0;
            s1_s     <= 1'b0;
            s1_class <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_sign;
                s1_e     <= e_n;
                s1_frac  <= frac_n;
                s1_g     <= g_n;
                s1_s     <= s_n;
                s1_class <= in_class;
            end
        end
    end

    // Stage 2: round, range-check and pack
    fp_round_rne u_round (
        .frac     (s1_frac),
        .g        (s1_g),
        .s        (s1_s),
        .e        (s1_e),
        .frac_rnd (frac_rnd),
        .e_adj    (e_adj),
        .carry    (carry),
        .inexact  (inexact)
    );

    always_comb begin
        res_data  = {s1_sign, e_adj[EXP_W-1:0], frac_rnd};
        res_flags = '0;
        res_flags[FLAG_INX] = inexact;
        if (e_adj >= $signed(E_W'(255))) begin
            res_data  = {s1_sign, 8'hFF, 23'h0};
            res_flags = '0;
            res_flags[FLAG_OVF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end else if (e_adj <= $signed(E_W'(0))) begin
            res_data  = {s1_sign, 31'h0};
            res_flags = '0;
            res_flags[FLAG_UNF] = 1'b1;
            res_flags[FLAG_INX] = 1'b1;
        end
        // Special operands resolved upstream win over any arithmetic result
        case (fp_class_e'(s1_class))
            FP_ZERO: begin
                res_data  = {s1_sign, 31'h0};
                res_flags = '0;
            end
            FP_INF: begin
                res_data  = {s1_sign, 8'hFF, 23'h0};
                res_flags = '0;
            end
            FP_NAN: begin
                res_data  = QNAN;
                res_flags = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= res_data;
                out_flags <= res_flags;
            end
        end
    end

    logic unused_carry;
    assign unused_carry = carry;
endmodule

// File: tb/tb_fmult_norm_round.sv
// Scoreboard bench for fmult_norm_round: directed corner cases, backpressure,
// mid-flight reset and randomized products against an integer reference model.
module tb_fmult_norm_round;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic [1:0]  in_class = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [34:0] exp_q[$];
    bit          rnd_ready = 1'b0;

    always #5 clk = ~clk;

    fmult_norm_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: treat the product as an integer, split off kept bits and the
    // remainder, and round by comparing the remainder with exactly one half.
    function automatic logic [34:0] model(input logic sg, input logic [8:0] ex,
                                          input logic [47:0] m, input logic [1:0] c);
        longint unsigned kept, rem, half;
        int sh, e;
        bit up, inx;
        case (c)
            2'b01: return {sg, 31'h0, 3'b000};
            2'b10: return {sg, 8'hFF, 23'h0, 3'b000};
            2'b11: return {32'h7FC0_0000, 3'b000};
            default: ;
        endcase
        sh   = m[47] ? 24 : 23;
        kept = {16'h0, m} >> sh;
        rem  = {16'h0, m} - (kept << sh);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || (rem == half && kept[0]);
        kept = kept + {63'd0, up};
        e    = int'(ex) - 127 + (m[47] ? 1 : 0);
        if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            e++;
        end
        inx = (rem != 0);
        if (e >= 255) return {sg, 8'hFF, 23'h0, 3'b101};
        if (e <= 0) return {sg, 31'h0, 3'b011};
        return {sg, 8'(e), kept[22:0], 2'b00, inx};
    endfunction

    always @(negedge clk) begin
        logic [34:0] ev;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", {out_data, out_flags});
            end else begin
                ev = exp_q.pop_front();
                check("result", {out_data, out_flags}, ev);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic drive(input logic s, input logic [8:0] e, input logic [47:0] m,
                         input logic [1:0] c, input logic [34:0] expv);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_class = c;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                tick();
                return;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_rand();
        logic [23:0] a, b;
        logic [47:0] m;
        logic [8:0]  e;
        logic [1:0]  c;
        logic        s;
        a = 24'h80_0000 | 24'($urandom);
        b = 24'h80_0000 | 24'($urandom);
        m = {24'h0, a} * {24'h0, b};
        e = 9'($urandom_range(510, 0));
        s = 1'($urandom);
        c = ($urandom_range(9) == 0) ? 2'($urandom) : 2'b00;
        drive(s, e, m, c, model(s, e, m, c));
    endtask

    initial begin
        logic [34:0] held;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 35'(out_valid), 35'(0));
        check("rst_out_data", 35'(out_data), 35'(0));
        check("rst_out_flags", 35'(out_flags), 35'(0));
        check("rst_in_ready", 35'(in_ready), 35'(1));
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        drive(1'b0, 9'd254, 48'h9000_0000_0000, 2'b00, {32'h4010_0000, 3'b000});
        in_valid = 1'b0;
        check("latency_stage1", 35'(out_valid), 35'(0));
        tick();
        check("latency_stage2", 35'(out_valid), 35'(1));

        drive(1'b0, 9'd254, 48'h4000_00C0_0000, 2'b00, {32'h3F80_0002, 3'b001});
        drive(1'b0, 9'd254, 48'h4000_0040_0000, 2'b00, {32'h3F80_0000, 3'b001});
        drive(1'b1, 9'd508, 48'h4000_0000_0000, 2'b00, {32'hFF80_0000, 3'b101});
        drive(1'b0, 9'd100, 48'h4000_0000_0000, 2'b00, {32'h0000_0000, 3'b011});
        drive(1'b0, 9'd254, 48'hFFFF_FF80_0000, 2'b00, {32'h4080_0000, 3'b001});
        drive(1'b0, 9'd380, 48'hFFFF_FF80_0000, 2'b00, {32'h7F80_0000, 3'b101});
        drive(1'b0, 9'd126, 48'hFFFF_FF80_0000, 2'b00, {32'h0080_0000, 3'b001});
        drive(1'b0, 9'd200, 48'h9000_0000_0000, 2'b11, {32'h7FC0_0000, 3'b000});
        drive(1'b1, 9'd508, 48'h9000_0000_0000, 2'b10, {32'hFF80_0000, 3'b000});
        drive(1'b1, 9'd100, 48'h9000_0000_0000, 2'b01, {32'h8000_0000, 3'b000});
        idle(4);

        out_ready = 1'b0;
        drive(1'b0, 9'd254, 48'h9000_0000_0000, 2'b00, model(1'b0, 9'd254, 48'h9000_0000_0000, 2'b00));
        drive(1'b1, 9'd260, 48'h6543_2100_1234, 2'b00, model(1'b1, 9'd260, 48'h6543_2100_1234, 2'b00));
        in_sign  = 1'b0;
        in_exp   = 9'd150;
        in_mant  = 48'hA5A5_5A5A_F00F;
        in_class = 2'b00;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", 35'(in_ready), 35'(0));
        check("bp_out_valid", 35'(out_valid), 35'(1));
        held = {out_data, out_flags};
        repeat (5) begin
            @(negedge clk);
            check("bp_stable", {out_data, out_flags}, held);
        end
        tick();
        out_ready = 1'b1;
        drive(1'b0, 9'd150, 48'hA5A5_5A5A_F00F, 2'b00, model(1'b0, 9'd150, 48'hA5A5_5A5A_F00F, 2'b00));
        idle(6);
        check("bp_drained", 35'(exp_q.size()), 35'(0));

        out_ready = 1'b0;
        drive(1'b1, 9'd300, 48'h8000_0000_0001, 2'b00, model(1'b1, 9'd300, 48'h8000_0000_0001, 2'b00));
        drive(1'b0, 9'd240, 48'h7000_0000_0000, 2'b00, model(1'b0, 9'd240, 48'h7000_0000_0000, 2'b00));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_out_valid_drop", 35'(out_valid), 35'(0));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_reset_in_ready", 35'(in_ready), 35'(1));
        idle(5);
        check("post_reset_no_stale", 35'(out_valid), 35'(0));

        rnd_ready = 1'b1;
        repeat (300) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
            send_rand();
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        idle(2);
        check("final_drain", 35'(exp_q.size()), 35'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
